result_drain_arbiter: RTL

//  Pointer controller and round-robin read scheduler for the per-port result RAMs (one simple dual-port RAM per port).

---
 rtl/result_drain_pkg.sv | 22 ++
 rtl/result_drain_arbiter_rr.sv | 35 +++
 rtl/result_drain_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/result_drain_pkg.sv
// Shared definitions for the result drain arbiter.
//   DEF_NPORTS / DEF_DATA_W / DEF_ADDR_W : default configuration
//   PSEL_W                               : width of a port index for the default NPORTS
//   drain_state_t                        : drain FSM states
//   qptr_t                               : queue pointer (one wrap bit above the RAM address)
package result_drain_pkg;

    localparam int DEF_NPORTS = 3;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 14;
    localparam int PSEL_W     = $clog2(DEF_NPORTS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        CAPT  = 2'd2,
        HOLD  = 2'd3
    } drain_state_t;

    typedef logic [DEF_ADDR_W:0] qptr_t;

endpackage

// File: rtl/result_drain_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick.
//   req     in  NPORTS  per-port request (queue non-empty)
//   last    in  SEL_W   port served most recently; search starts at last+1
//   grant   out SEL_W   first requesting port found, 0 when none
//   any_req out 1       at least one request present
module rr_arbiter
    import result_drain_pkg::*;
#(
    parameter int NPORTS = DEF_NPORTS,
    parameter int SEL_W  = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
    input  logic [NPORTS-1:0] req,
    input  logic [SEL_W-1:0]  last,
    output logic [SEL_W-1:0]  grant,
    output logic              any_req
);

    logic found;

    always_comb begin
        grant   = '0;
        found   = 1'b0;
        any_req = |req;
        // i runs 1..NPORTS so the last-served port is considered last.
        for (int i = 1; i <= NPORTS; i++) begin
            int idx;
            idx = (int'(last) + i) % NPORTS;
            if (!found && req[idx]) begin
                grant = SEL_W'(idx);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/result_drain_arbiter.sv
// result_drain_arbiter: pointer controller and round-robin read scheduler for
// NPORTS result RAMs (one simple dual-port RAM per port). Drains one entry at a
// time into a valid/ready stream.
// Ports:
//   clk, reset (async, active-high)
//   wr_en/wr_gnt/wr_addr : producer strobes, per-port RAM write enables/addresses
//   rd_en/rd_sel/rd_addr : single read request into the muxed RAM bank
//   ram_q                : muxed RAM output, valid the cycle after rd_en
//   out_valid/out_ready/out_data/out_port : drained word stream
//   ovf                  : sticky per-port overflow flags
// Build option: OVF_DETECT_EN - when defined, writes to a full queue are
// dropped and flagged in ovf; otherwise they overwrite the oldest slot.
module result_drain_arbiter
    import result_drain_pkg::*;
#(
    parameter int NPORTS = DEF_NPORTS,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    localparam int SEL_W = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NPORTS-1:0]        wr_en,
    output logic [NPORTS-1:0]        wr_gnt,
    output logic [NPORTS*ADDR_W-1:0] wr_addr,
    output logic                     rd_en,
    output logic [SEL_W-1:0]         rd_sel,
    output logic [ADDR_W-1:0]        rd_addr,
    input  logic [DATA_W-1:0]        ram_q,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_port,
    output logic [NPORTS-1:0]        ovf
);

    logic [ADDR_W:0]   wr_ptr [NPORTS];
    logic [ADDR_W:0]   rd_ptr [NPORTS];
    logic [NPORTS-1:0] empty;
    logic [NPORTS-1:0] rd_adv;

    drain_state_t      state, state_nxt;
    logic [SEL_W-1:0]  grant;
    logic [SEL_W-1:0]  rr_last;
    logic [SEL_W-1:0]  arb_grant;
    logic              any_req;

    always_comb begin
        empty   = '0;
        rd_adv  = '0;
        wr_addr = '0;
        for (int p = 0; p < NPORTS; p++) begin
            // Registered wr_ptr: a freshly written slot becomes eligible next cycle.
            empty[p]                    = (wr_ptr[p] == rd_ptr[p]);
            rd_adv[p]                   = (state == CAPT) && (grant == SEL_W'(p));
            wr_addr[p*ADDR_W +: ADDR_W] = wr_ptr[p][ADDR_W-1:0];
        end
    end

`ifdef OVF_DETECT_EN
    logic [NPORTS-1:0] full;

    always_comb begin
        full = '0;
        for (int p = 0; p < NPORTS; p++) begin
            full[p] = (wr_ptr[p][ADDR_W] != rd_ptr[p][ADDR_W]) &&
                      (wr_ptr[p][ADDR_W-1:0] == rd_ptr[p][ADDR_W-1:0]);
        end
    end

    assign wr_gnt = wr_en & ~full & {NPORTS{~reset}};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf <= '0;
        end else begin
            ovf <= ovf | (wr_en & full);
        end
    end
`else
    // No full check: a write to a full queue overwrites the oldest slot.
    assign wr_gnt = wr_en & {NPORTS{~reset}};
    assign ovf    = '0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < NPORTS; p++) begin
                wr_ptr[p] <= '0;
                rd_ptr[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NPORTS; p++) begin
                if (wr_gnt[p]) wr_ptr[p] <= wr_ptr[p] + 1'b1;
                if (rd_adv[p]) rd_ptr[p] <= rd_ptr[p] + 1'b1;
            end
        end
    end

    rr_arbiter #(
        .NPORTS (NPORTS),
        .SEL_W  (SEL_W)
    ) u_rr (
        .req     (~empty),
        .last    (rr_last),
        .grant   (arb_grant),
        .any_req (any_req)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        case (state)
            IDLE:    if (any_req) state_nxt = ISSUE;
            ISSUE: begin
                rd_en     = 1'b1;
                state_nxt = CAPT;
            end
            CAPT:    state_nxt = HOLD;
            HOLD:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign rd_sel = grant;

    always_comb begin
        rd_addr = '0;
        for (int p = 0; p < NPORTS; p++) begin
            if (grant == SEL_W'(p)) rd_addr = rd_ptr[p][ADDR_W-1:0];
        end
    end

    // Arbitration (IDLE) -> read issue (ISSUE) -> capture (CAPT) -> hold (HOLD)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant     <= '0;
            rr_last   <= SEL_W'(NPORTS - 1);
            out_valid <= 1'b0;
            out_data  <= '0;
            out_port  <= '0;
        end else begin
            if (state == IDLE && any_req) grant <= arb_grant;
            if (state == CAPT) begin
                out_data  <= ram_q;
                out_port  <= grant;
                out_valid <= 1'b1;
                rr_last   <= grant;
            end else if (state == HOLD && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
